// File: rtl/immgen_stage.sv
// immgen_stage: registered, valid/ready immediate generator for RV32/RV64.
// Define IMMGEN_SKID_EN to add a skid entry and a flop-driven in_ready.
module immgen_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_inst,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_fmt,
  output logic                  out_illegal
);

  localparam bit RV64 = (DATA_WIDTH == 64);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSRI  = 3'd7;

  typedef struct packed {
    logic [31:0]           inst;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] imm;
    logic [2:0]            fmt;
    logic                  ill;
  } entry_t;

  logic [4:0] opc;
  logic [2:0] f3;
  logic       quad_ok;

  assign opc     = in_inst[6:2];
  assign f3      = in_inst[14:12];
  assign quad_ok = &in_inst[1:0];

  logic is_ild, is_st, is_br, is_jal, is_u;
  logic is_op, is_op32, is_opi, is_opi32, is_sys;

  assign is_ild   = quad_ok && (opc == 5'b00000 ||
                                opc == 5'b00011 ||
                                opc == 5'b11001);
  assign is_st    = quad_ok && opc == 5'b01000;
  assign is_br    = quad_ok && opc == 5'b11000;
  assign is_jal   = quad_ok && opc == 5'b11011;
  assign is_u     = quad_ok && (opc == 5'b01101 ||
                                opc == 5'b00101);
  assign is_op    = quad_ok && opc == 5'b01100;
  assign is_op32  = quad_ok && opc == 5'b01110;
  assign is_opi   = quad_ok && opc == 5'b00100;
  assign is_opi32 = quad_ok && opc == 5'b00110;
  assign is_sys   = quad_ok && opc == 5'b11100;

  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b;
  logic [DATA_WIDTH-1:0] imm_j, imm_u, imm_csr;
  logic [DATA_WIDTH-1:0] sh64, sh32;

  assign imm_i = DATA_WIDTH'($signed(in_inst[31:20]));
  assign imm_s = DATA_WIDTH'($signed(
                   {in_inst[31:25], in_inst[11:7]}));
  assign imm_b = DATA_WIDTH'($signed(
                   {in_inst[31], in_inst[7],
                    in_inst[30:25], in_inst[11:8],
                    1'b0}));
  assign imm_j = DATA_WIDTH'($signed(
                   {in_inst[31], in_inst[19:12],
                    in_inst[20], in_inst[30:21],
                    1'b0}));
  assign imm_u = DATA_WIDTH'($signed(
                   {in_inst[31:12], 12'b0}));
  assign imm_csr = DATA_WIDTH'(in_inst[19:15]);
  assign sh64    = DATA_WIDTH'(in_inst[25:20]);
  assign sh32    = DATA_WIDTH'(in_inst[24:20]);

  logic       is_sh;
  logic       sh64_ok, sh32_ok;
  logic [5:0] hi6;
  logic [6:0] hi7;

  assign is_sh = (f3[1:0] == 2'b01);
  assign hi6   = in_inst[31:26];
  assign hi7   = in_inst[31:25];

  // SRLI/SRAI allow only bit 30 above the shamt field.
  assign sh64_ok = f3[2] ? (hi6 == 6'b000000 ||
                            hi6 == 6'b010000)
                         : (hi6 == 6'b000000);
  assign sh32_ok = !in_inst[25] &&
                   (f3[2] ? (hi7 == 7'b0000000 ||
                             hi7 == 7'b0100000)
                          : (hi7 == 7'b0000000));

  logic [DATA_WIDTH-1:0] d_imm;
  logic [2:0]            d_fmt;
  logic                  d_ill;

  // Decode the incoming word into immediate, format and legality.
  always_comb begin
    d_imm = '0;
    d_fmt = FMT_NONE;
    d_ill = 1'b0;
    unique case (1'b1)
      is_ild: begin
        d_fmt = FMT_I;
        d_imm = imm_i;
      end
      is_st: begin
        d_fmt = FMT_S;
        d_imm = imm_s;
      end
      is_br: begin
        d_fmt = FMT_B;
        d_imm = imm_b;
      end
      is_jal: begin
        d_fmt = FMT_J;
        d_imm = imm_j;
      end
      is_u: begin
        d_fmt = FMT_U;
        d_imm = imm_u;
      end
      is_op: begin
        d_fmt = FMT_NONE;
      end
      is_op32: begin
        d_ill = !RV64;
      end
      is_opi: begin
        if (is_sh) begin
          if (RV64 ? sh64_ok : sh32_ok) begin
            d_fmt = FMT_SHAMT;
            d_imm = RV64 ? sh64 : sh32;
          end else begin
            d_ill = 1'b1;
          end
        end else begin
          d_fmt = FMT_I;
          d_imm = imm_i;
        end
      end
      is_opi32: begin
        if (!RV64) begin
          d_ill = 1'b1;
        end else if (is_sh) begin
          if (sh32_ok) begin
            d_fmt = FMT_SHAMT;
            d_imm = sh32;
          end else begin
            d_ill = 1'b1;
          end
        end else begin
          d_fmt = FMT_I;
          d_imm = imm_i;
        end
      end
      is_sys: begin
        if (f3 == 3'b100) begin
          d_ill = 1'b1;
        end else if (f3[2]) begin
          d_fmt = FMT_CSRI;
          d_imm = imm_csr;
        end else begin
          d_fmt = FMT_I;
          d_imm = imm_i;
        end
      end
      default: begin
        d_ill = 1'b1;
      end
    endcase
    if (d_ill) begin
      d_imm = '0;
      d_fmt = FMT_NONE;
    end
  end

  entry_t new_e;

  // Bundle the decoded result with its instruction and tag.
  always_comb begin
    new_e      = '0;
    new_e.inst = in_inst;
    new_e.tag  = in_tag;
    new_e.imm  = d_imm;
    new_e.fmt  = d_fmt;
    new_e.ill  = d_ill;
  end

  entry_t main_q, main_d;
  logic   mv_q, mv_d;
  logic   rdy_q, rdy_d;
  logic   in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = mv_q && out_ready;

`ifdef IMMGEN_SKID_EN
  entry_t skid_q, skid_d;
  logic   sv_q, sv_d;

  assign in_ready = rdy_q;

  // Main entry refills from skid first so order is kept.
  always_comb begin
    main_d = main_q;
    mv_d   = mv_q;
    skid_d = skid_q;
    sv_d   = sv_q;
    if (!mv_q || out_ready) begin
      if (sv_q) begin
        main_d = skid_q;
        mv_d   = 1'b1;
        sv_d   = 1'b0;
      end else begin
        mv_d = in_fire;
        if (in_fire) begin
          main_d = new_e;
        end
      end
    end else if (in_fire) begin
      skid_d = new_e;
      sv_d   = 1'b1;
    end
    rdy_d = !sv_d;
  end

  // Skid entry register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '0;
      sv_q   <= 1'b0;
    end else begin
      skid_q <= skid_d;
      sv_q   <= sv_d;
    end
  end
`else
  assign in_ready = rdy_q && (!mv_q || out_ready);

  // Single entry: load on accept, empty on drain.
  always_comb begin
    main_d = main_q;
    mv_d   = mv_q;
    if (out_fire) begin
      mv_d = 1'b0;
    end
    if (in_fire) begin
      main_d = new_e;
      mv_d   = 1'b1;
    end
    rdy_d = 1'b1;
  end
`endif

  // Main entry and ready gate; ready stays low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      mv_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      main_q <= main_d;
      mv_q   <= mv_d;
      rdy_q  <= rdy_d;
    end
  end

  assign out_valid   = mv_q;
  assign out_inst    = main_q.inst;
  assign out_tag     = main_q.tag;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_immgen_stage.sv
// tb_immgen_stage: RV32 and RV64 instances driven in lockstep,
// checked against a queue-based reference of the stage.
module tb_immgen_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  logic        rdy32, rdy64, ov32, ov64;
  logic [31:0] oi32, oi64, ot32, ot64;
  logic [31:0] im32;
  logic [63:0] im64;
  logic [2:0]  of32, of64;
  logic        il32, il64;

  always #5 clk = ~clk;

  immgen_stage #(.DATA_WIDTH(32), .TAG_WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready),
    .out_inst(oi32), .out_tag(ot32),
    .out_imm(im32), .out_fmt(of32),
    .out_illegal(il32)
  );

  immgen_stage #(.DATA_WIDTH(64), .TAG_WIDTH(32)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready),
    .out_inst(oi64), .out_tag(ot64),
    .out_imm(im64), .out_fmt(of64),
    .out_illegal(il64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } exp_t;

  exp_t        q[$];
  logic [31:0] popped[$];
  bit          rdy_m;
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode from the ISA field rules on a 64-bit integer.
  function automatic void ref_dec(input logic [31:0] w,
                                  input int xl,
                                  output logic [63:0] imm,
                                  output int fmt,
                                  output bit ill);
    longint s, u, hi;
    int op, f3, n;
    s = longint'($signed(w));
    u = longint'({32'b0, w});
    op = int'(u & 'h7f);
    f3 = int'((u >> 12) & 7);
    imm = '0;
    fmt = 0;
    ill = 1'b0;
    case (op)
      'h03, 'h0f, 'h67: begin
        fmt = 1;
        imm = s >>> 20;
      end
      'h23: begin
        fmt = 2;
        imm = ((s >>> 25) << 5) | ((u >> 7) & 31);
      end
      'h63: begin
        fmt = 3;
        imm = ((s >>> 31) << 12) | (((u >> 7) & 1) << 11)
            | (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      end
      'h6f: begin
        fmt = 5;
        imm = ((s >>> 31) << 20) | (((u >> 12) & 255) << 12)
            | (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      end
      'h37, 'h17: begin
        fmt = 4;
        imm = s & ~longint'(4095);
      end
      'h33: fmt = 0;
      'h3b: ill = (xl == 32);
      'h13, 'h1b: begin
        if (op == 'h1b && xl == 32) begin
          ill = 1'b1;
        end else if (f3 == 1 || f3 == 5) begin
          n = (op == 'h13 && xl == 64) ? 6 : 5;
          hi = u >> (20 + n);
          if (hi == 0 ||
              (f3 == 5 && hi == (longint'(1) << (10 - n)))) begin
            fmt = 6;
            imm = (u >> 20) & ((longint'(1) << n) - 1);
          end else begin
            ill = 1'b1;
          end
        end else begin
          fmt = 1;
          imm = s >>> 20;
        end
      end
      'h73: begin
        if (f3 == 4) begin
          ill = 1'b1;
        end else if (f3 >= 4) begin
          fmt = 7;
          imm = (u >> 15) & 31;
        end else begin
          fmt = 1;
          imm = s >>> 20;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      imm = '0;
      fmt = 0;
    end else if (xl == 32) begin
      imm = imm & 64'h0000_0000_ffff_ffff;
    end
  endfunction

  task automatic chk_out(input exp_t e);
    logic [63:0] im;
    int f;
    bit il;
    ref_dec(e.inst, 32, im, f, il);
    chk("imm32", {32'b0, im32}, im);
    chk("fmt32", {61'b0, of32}, 64'(f));
    chk("ill32", {63'b0, il32}, {63'b0, il});
    chk("inst32", {32'b0, oi32}, {32'b0, e.inst});
    chk("tag32", {32'b0, ot32}, {32'b0, e.tag});
    ref_dec(e.inst, 64, im, f, il);
    chk("imm64", im64, im);
    chk("fmt64", {61'b0, of64}, 64'(f));
    chk("ill64", {63'b0, il64}, {63'b0, il});
    chk("tag64", {32'b0, ot64}, {32'b0, e.tag});
  endtask

  function automatic bit exp_ready(input bit ordy);
`ifdef IMMGEN_SKID_EN
    return rdy_m && (q.size() < 2);
`else
    return rdy_m && (q.size() == 0 || ordy);
`endif
  endfunction

  // One cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input bit v, input logic [31:0] w,
                      input logic [31:0] t, input bit ordy,
                      output bit acc);
    bit er, pop;
    exp_t e;
    in_valid = v;
    in_inst = w;
    in_tag = t;
    out_ready = ordy;
    @(negedge clk);
    er = exp_ready(ordy);
    chk("in_ready32", {63'b0, rdy32}, {63'b0, er});
    chk("in_ready64", {63'b0, rdy64}, {63'b0, er});
    chk("out_valid32", {63'b0, ov32}, {63'b0, q.size() > 0});
    chk("out_valid64", {63'b0, ov64}, {63'b0, q.size() > 0});
    if (q.size() > 0) chk_out(q[0]);
    acc = v && er;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    if (pop) begin
      popped.push_back(q[0].tag);
      void'(q.pop_front());
    end
    if (acc) begin
      e.inst = w;
      e.tag = t;
      q.push_back(e);
    end
    rdy_m = 1'b1;
    #1;
  endtask

  // Directed word with hand-derived expectations for both widths.
  task automatic dir(input logic [31:0] w,
                     input logic [63:0] e32, input int f32, input bit i32,
                     input logic [63:0] e64, input int f64, input bit i64);
    bit acc;
    step(1'b1, w, w ^ 32'h5a5a, 1'b1, acc);
    in_valid = 1'b0;
    @(negedge clk);
    chk("d_valid", {63'b0, ov32 & ov64}, 64'd1);
    chk("d_imm32", {32'b0, im32}, e32);
    chk("d_fmt32", {61'b0, of32}, 64'(f32));
    chk("d_ill32", {63'b0, il32}, {63'b0, i32});
    chk("d_imm64", im64, e64);
    chk("d_fmt64", {61'b0, of64}, 64'(f64));
    chk("d_ill64", {63'b0, il64}, {63'b0, i64});
    @(posedge clk);
    void'(q.pop_front());
    #1;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    logic [6:0] ops[13];
    logic [6:0] his[4];
    ops = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33,
            7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73};
    his = '{7'h00, 7'h20, 7'h21, 7'h01};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      w[6:0] = ops[$urandom_range(0, 12)];
    end
    if ($urandom_range(0, 2) == 0) begin
      w[31:25] = his[$urandom_range(0, 3)];
    end
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int idx;
    n_vec = 0;
    n_err = 0;
    rdy_m = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {62'b0, rdy32, rdy64}, 64'd0);
    chk("rst_valid", {62'b0, ov32, ov64}, 64'd0);
    chk("rst_imm", im64 | {32'b0, im32}, 64'd0);
    chk("rst_fmt", {58'b0, of32, of64}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    step(1'b0, '0, '0, 1'b1, acc);

    dir(32'hFFF00093, 64'hFFFFFFFF, 1, 1'b0,
        64'hFFFFFFFF_FFFFFFFF, 1, 1'b0);
    dir(32'hFE000EE3, 64'hFFFFFFFC, 3, 1'b0,
        64'hFFFFFFFF_FFFFFFFC, 3, 1'b0);
    dir(32'h0080006F, 64'd8, 5, 1'b0, 64'd8, 5, 1'b0);
    dir(32'h4030D093, 64'd3, 6, 1'b0, 64'd3, 6, 1'b0);
    dir(32'h4230D093, 64'd0, 0, 1'b1, 64'd35, 6, 1'b0);
    dir(32'h3401D073, 64'd3, 7, 1'b0, 64'd3, 7, 1'b0);
    dir(32'h80000037, 64'h80000000, 4, 1'b0,
        64'hFFFFFFFF_80000000, 4, 1'b0);
    dir(32'h0000001B, 64'd0, 0, 1'b1, 64'd0, 1, 1'b0);
    dir(32'h00004073, 64'd0, 0, 1'b1, 64'd0, 0, 1'b1);
    dir(32'h00000092, 64'd0, 0, 1'b1, 64'd0, 0, 1'b1);

    // Tags 1,2,3 back-to-back; stalled three cycles.
    popped.delete();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      step(idx < 3, 32'h00100093 + (idx << 20), idx + 1,
           c >= 3, acc);
      if (acc) idx++;
    end
    chk("stream_acc", 64'(idx), 64'd3);
    chk("stream_cnt", 64'(popped.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk("stream_ord",
          (k < popped.size()) ? {32'b0, popped[k]} : 64'hdead,
          64'(k + 1));
    end

    // Reset in the middle of a stall.
    step(1'b1, 32'h00500113, 32'h77, 1'b0, acc);
    step(1'b1, 32'h00600193, 32'h78, 1'b0, acc);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {62'b0, ov32, ov64}, 64'd0);
    chk("mid_rst_ready", {62'b0, rdy32, rdy64}, 64'd0);
    chk("mid_rst_tag", {32'b0, ot32 | ot64}, 64'd0);
    q.delete();
    rdy_m = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, '0, '0, 1'b1, acc);

    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 9) < 7, rnd_inst(), $urandom,
           $urandom_range(0, 9) < 7, acc);
    end

    for (int c = 0; c < 6 && q.size() > 0; c++) begin
      step(1'b0, '0, '0, 1'b1, acc);
    end
    chk("drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
